// File: rtl/fc_topk_collector.sv
// Running top-K (class, logit) tracker over one FC logit frame; the table updates on the accepting edge and is visible one cycle later.
// No backpressure: one beat per cycle is always accepted in COLLECT. The optional idle timeout is enabled by FC_TOPK_TIMEOUT_EN.
module fc_topk_collector #(
    parameter int NUM_CLASSES    = 1000,
    parameter int K              = 5,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                start,
    input  logic                fc_out_valid,
    input  logic [10:0]         fc_out_class_idx,
    input  logic signed [7:0]   fc_out_logit,
    output logic                busy,
    output logic                result_valid,
    output logic [10:0]         top1_idx,
    output logic signed [7:0]   top1_logit,
    output logic [11*K-1:0]     topk_idx_flat,
    output logic [8*K-1:0]      topk_logit_flat,
    output logic [K-1:0]        topk_valid,
    output logic [10:0]         beat_count,
    output logic                seq_err,
    output logic                drop_err,
    output logic                timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [10:0]           r_tbl_idx   [K];
    logic signed [7:0]     r_tbl_logit [K];
    logic [K-1:0]          r_tbl_vld;
    logic [10:0]           w_tbl_idx_nxt   [K];
    logic signed [7:0]     w_tbl_logit_nxt [K];
    logic [K-1:0]          w_tbl_vld_nxt;
    logic [K-1:0]          w_outrank;
    logic [10:0]           r_beat_cnt;
    logic                  r_seq_err;
    logic                  r_drop_err;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_timeout;

    assign w_accept = (r_state == S_COLLECT) && fc_out_valid && !start;
    assign w_last   = w_accept && (r_beat_cnt == 11'(NUM_CLASSES - 1));

    // Table is sorted descending with empties at the bottom, so w_outrank is
    // monotonic: once set at rank r it stays set for every lower rank.
    genvar g;
    generate
        for (g = 0; g < K; g++) begin : g_rank
            assign w_outrank[g] = !r_tbl_vld[g] || (fc_out_logit > r_tbl_logit[g]);
            if (g == 0) begin : g_top
                always_comb begin
                    w_tbl_idx_nxt[g]   = r_tbl_idx[g];
                    w_tbl_logit_nxt[g] = r_tbl_logit[g];
                    w_tbl_vld_nxt[g]   = r_tbl_vld[g];
                    if (w_outrank[g]) begin
                        w_tbl_idx_nxt[g]   = fc_out_class_idx;
                        w_tbl_logit_nxt[g] = fc_out_logit;
                        w_tbl_vld_nxt[g]   = 1'b1;
                    end
                end
            end else begin : g_low
                always_comb begin
                    w_tbl_idx_nxt[g]   = r_tbl_idx[g];
                    w_tbl_logit_nxt[g] = r_tbl_logit[g];
                    w_tbl_vld_nxt[g]   = r_tbl_vld[g];
                    if (w_outrank[g] && !w_outrank[g-1]) begin
                        w_tbl_idx_nxt[g]   = fc_out_class_idx;
                        w_tbl_logit_nxt[g] = fc_out_logit;
                        w_tbl_vld_nxt[g]   = 1'b1;
                    end else if (w_outrank[g]) begin
                        w_tbl_idx_nxt[g]   = r_tbl_idx[g-1];
                        w_tbl_logit_nxt[g] = r_tbl_logit[g-1];
                        w_tbl_vld_nxt[g]   = r_tbl_vld[g-1];
                    end
                end
            end
            assign topk_idx_flat[11*g +: 11]  = r_tbl_idx[g];
            assign topk_logit_flat[8*g +: 8]  = r_tbl_logit[g];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = S_COLLECT;
        end else if (r_state == S_COLLECT && (w_last || w_timeout)) begin
            w_state_nxt = S_DONE;
        end
    end

    always_comb begin
        busy         = (r_state == S_COLLECT);
        result_valid = (r_state == S_DONE);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int r = 0; r < K; r++) begin
                r_tbl_idx[r]   <= 11'h7FF;
                r_tbl_logit[r] <= -8'sd128;
            end
            r_tbl_vld  <= '0;
            r_beat_cnt <= '0;
            r_seq_err  <= 1'b0;
            r_drop_err <= 1'b0;
        end else if (start) begin
            for (int r = 0; r < K; r++) begin
                r_tbl_idx[r]   <= 11'h7FF;
                r_tbl_logit[r] <= -8'sd128;
            end
            r_tbl_vld  <= '0;
            r_beat_cnt <= '0;
            r_seq_err  <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int r = 0; r < K; r++) begin
                    r_tbl_idx[r]   <= w_tbl_idx_nxt[r];
                    r_tbl_logit[r] <= w_tbl_logit_nxt[r];
                end
                r_tbl_vld  <= w_tbl_vld_nxt;
                r_beat_cnt <= r_beat_cnt + 11'd1;
                if (fc_out_class_idx != r_beat_cnt) begin
                    r_seq_err <= 1'b1;
                end
            end
            if (fc_out_valid && r_state != S_COLLECT) begin
                r_drop_err <= 1'b1;
            end
        end
    end

`ifdef FC_TOPK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_idle_cnt;
    logic          r_timeout_err;

    // Fires on the edge that completes the TIMEOUT_CYCLES-th consecutive idle cycle.
    assign w_timeout = (r_state == S_COLLECT) && !start && !fc_out_valid &&
                       (r_idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else if (start) begin
            r_idle_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != S_COLLECT || fc_out_valid) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign top1_idx    = r_tbl_idx[0];
    assign top1_logit  = r_tbl_logit[0];
    assign topk_valid  = r_tbl_vld;
    assign beat_count  = r_beat_cnt;
    assign seq_err     = r_seq_err;
    assign drop_err    = r_drop_err;

endmodule

// File: tb/tb_fc_topk_collector.sv
// Directed bench: three collector instances (8/3, 4/5, 1000/3) share one stimulus stream; each scenario checks one instance.
module tb_fc_topk_collector;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        start;
    logic        fc_out_valid;
    logic [10:0] fc_out_class_idx;
    logic [7:0]  fc_out_logit;

    always #5 CLK = ~CLK;

    logic a_busy, a_rv, a_se, a_de, a_te;
    logic [10:0] a_t1i, a_bc;
    logic [7:0]  a_t1l;
    logic [32:0] a_ki;
    logic [23:0] a_kl;
    logic [2:0]  a_kv;

    logic b_busy, b_rv, b_se, b_de, b_te;
    logic [10:0] b_t1i, b_bc;
    logic [7:0]  b_t1l;
    logic [54:0] b_ki;
    logic [39:0] b_kl;
    logic [4:0]  b_kv;

    logic c_busy, c_rv, c_se, c_de, c_te;
    logic [10:0] c_t1i, c_bc;
    logic [7:0]  c_t1l;
    logic [32:0] c_ki;
    logic [23:0] c_kl;
    logic [2:0]  c_kv;

    fc_topk_collector #(.NUM_CLASSES(8), .K(3), .TIMEOUT_CYCLES(16)) dut_a (
        .CLK(CLK), .RESETn(RESETn), .start(start), .fc_out_valid(fc_out_valid),
        .fc_out_class_idx(fc_out_class_idx), .fc_out_logit(fc_out_logit),
        .busy(a_busy), .result_valid(a_rv), .top1_idx(a_t1i), .top1_logit(a_t1l),
        .topk_idx_flat(a_ki), .topk_logit_flat(a_kl), .topk_valid(a_kv),
        .beat_count(a_bc), .seq_err(a_se), .drop_err(a_de), .timeout_err(a_te));

    fc_topk_collector #(.NUM_CLASSES(4), .K(5), .TIMEOUT_CYCLES(4096)) dut_b (
        .CLK(CLK), .RESETn(RESETn), .start(start), .fc_out_valid(fc_out_valid),
        .fc_out_class_idx(fc_out_class_idx), .fc_out_logit(fc_out_logit),
        .busy(b_busy), .result_valid(b_rv), .top1_idx(b_t1i), .top1_logit(b_t1l),
        .topk_idx_flat(b_ki), .topk_logit_flat(b_kl), .topk_valid(b_kv),
        .beat_count(b_bc), .seq_err(b_se), .drop_err(b_de), .timeout_err(b_te));

    fc_topk_collector #(.NUM_CLASSES(1000), .K(3), .TIMEOUT_CYCLES(4096)) dut_c (
        .CLK(CLK), .RESETn(RESETn), .start(start), .fc_out_valid(fc_out_valid),
        .fc_out_class_idx(fc_out_class_idx), .fc_out_logit(fc_out_logit),
        .busy(c_busy), .result_valid(c_rv), .top1_idx(c_t1i), .top1_logit(c_t1l),
        .topk_idx_flat(c_ki), .topk_logit_flat(c_kl), .topk_valid(c_kv),
        .beat_count(c_bc), .seq_err(c_se), .drop_err(c_de), .timeout_err(c_te));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one beat after a falling edge; returns on the next falling edge.
    task automatic beat(input int idx, input int lg);
        start            = 1'b0;
        fc_out_valid     = 1'b1;
        fc_out_class_idx = idx[10:0];
        fc_out_logit     = lg[7:0];
        @(negedge CLK);
        fc_out_valid     = 1'b0;
    endtask

    task automatic pulse_start();
        fc_out_valid = 1'b0;
        start        = 1'b1;
        @(negedge CLK);
        start        = 1'b0;
    endtask

    task automatic idle(input int n);
        fc_out_valid = 1'b0;
        start        = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    typedef struct {
        int          idx;
        int          lg;
        logic [10:0] t1i;
        logic [7:0]  t1l;
        logic [10:0] r2i;
        logic [10:0] bc;
        logic        rv;
    } vec_t;

    vec_t v[8];

    initial begin
        v[0] = '{0,    3, 11'd0, 8'h03, 11'h7FF, 11'd1, 1'b0};
        v[1] = '{1,   -5, 11'd0, 8'h03, 11'h7FF, 11'd2, 1'b0};
        v[2] = '{2,   10, 11'd2, 8'h0A, 11'd1,   11'd3, 1'b0};
        v[3] = '{3,    7, 11'd2, 8'h0A, 11'd0,   11'd4, 1'b0};
        v[4] = '{4,   10, 11'd2, 8'h0A, 11'd3,   11'd5, 1'b0};
        v[5] = '{5, -128, 11'd2, 8'h0A, 11'd3,   11'd6, 1'b0};
        v[6] = '{6,    0, 11'd2, 8'h0A, 11'd3,   11'd7, 1'b0};
        v[7] = '{7,    9, 11'd2, 8'h0A, 11'd7,   11'd8, 1'b1};

        RESETn = 1'b0; start = 1'b0; fc_out_valid = 1'b0;
        fc_out_class_idx = '0; fc_out_logit = '0;
        repeat (2) @(negedge CLK);
        chk("rst_busy", a_busy, 0);
        chk("rst_rv", a_rv, 0);
        chk("rst_bc", a_bc, 0);
        chk("rst_errs", {a_se, a_de, a_te}, 0);
        chk("rst_kv", a_kv, 0);
        chk("rst_ki", a_ki, {11'h7FF, 11'h7FF, 11'h7FF});
        chk("rst_kl", a_kl, 24'h808080);
        RESETn = 1'b1;
        @(negedge CLK);

        // Beat while IDLE, then start together with a beat.
        beat(0, 5);
        chk("idle_drop", a_de, 1);
        chk("idle_bc", a_bc, 0);
        start = 1'b1; fc_out_valid = 1'b1; fc_out_class_idx = 11'd0; fc_out_logit = 8'd50;
        @(negedge CLK);
        start = 1'b0; fc_out_valid = 1'b0;
        chk("st_drop_clr", a_de, 0);
        chk("st_bc", a_bc, 0);
        chk("st_busy", a_busy, 1);
        chk("st_kv", a_kv, 0);

        // Frame of 8 on dut_a, table-driven.
        for (int i = 0; i < 8; i++) begin
            beat(v[i].idx, v[i].lg);
            chk($sformatf("v%0d_t1i", i), a_t1i, v[i].t1i);
            chk($sformatf("v%0d_t1l", i), a_t1l, v[i].t1l);
            chk($sformatf("v%0d_r2i", i), a_ki[32:22], v[i].r2i);
            chk($sformatf("v%0d_bc", i), a_bc, v[i].bc);
            chk($sformatf("v%0d_rv", i), a_rv, v[i].rv);
        end
        chk("f8_ki", a_ki, {11'd7, 11'd4, 11'd2});
        chk("f8_kl", a_kl, {8'd9, 8'd10, 8'd10});
        chk("f8_kv", a_kv, 3'b111);
        chk("f8_se", a_se, 0);
        chk("f8_busy", a_busy, 0);
        idle(3);
        chk("done_hold", a_rv, 1);
        beat(9, 100);
        chk("done_drop", a_de, 1);
        chk("done_tbl", a_t1i, 11'd2);
        chk("done_bc", a_bc, 11'd8);

        // NUM_CLASSES=4, K=5, all minimum logits.
        pulse_start();
        for (int i = 0; i < 4; i++) beat(i, -128);
        chk("m4_kv", b_kv, 5'b01111);
        chk("m4_ki", b_ki, {11'h7FF, 11'd3, 11'd2, 11'd1, 11'd0});
        chk("m4_kl4", b_kl[39:32], 8'h80);
        chk("m4_rv", b_rv, 1);

        // Out-of-order class index.
        pulse_start();
        beat(0, 1);
        beat(1, 2);
        chk("seq_ok", b_se, 0);
        beat(3, 3);
        chk("seq_err", b_se, 1);
        beat(3, 4);
        chk("seq_bc", b_bc, 11'd4);
        chk("seq_rv", b_rv, 1);
        chk("seq_t1", {b_t1i, b_t1l}, {11'd3, 8'd4});
        chk("seq_sticky", b_se, 1);

        // Abort mid-frame on dut_c, then a full frame.
        pulse_start();
        for (int i = 0; i < 500; i++) beat(i, 127);
        chk("ab_bc500", c_bc, 11'd500);
        pulse_start();
        chk("ab_bc0", c_bc, 0);
        chk("ab_busy", c_busy, 1);
        chk("ab_kv", c_kv, 0);
        chk("ab_t1i", c_t1i, 11'h7FF);
        for (int i = 0; i < 1000; i++) begin
            beat(i, i % 120);
            if (i == 998) begin
                chk("ab_rv999", c_rv, 0);
                chk("ab_busy999", c_busy, 1);
            end
        end
        chk("ab_rv", c_rv, 1);
        chk("ab_bc", c_bc, 11'd1000);
        chk("ab_t1", {c_t1i, c_t1l}, {11'd119, 8'd119});
        chk("ab_ki", c_ki, {11'd359, 11'd239, 11'd119});

        // Asynchronous reset between clock edges.
        pulse_start();
        beat(0, 20); beat(1, 30); beat(2, 40);
        #3 RESETn = 1'b0;
        #1;
        chk("ar_busy", c_busy, 0);
        chk("ar_bc", c_bc, 0);
        chk("ar_kv", c_kv, 0);
        chk("ar_t1", {c_t1i, c_t1l}, {11'h7FF, 8'h80});
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);

        // Idle timeout on dut_a (TIMEOUT_CYCLES=16).
        pulse_start();
        beat(0, 5); beat(1, 6); beat(2, 7);
        idle(15);
        chk("to_rv15", a_rv, 0);
        idle(1);
`ifdef FC_TOPK_TIMEOUT_EN
        chk("to_rv", a_rv, 1);
        chk("to_err", a_te, 1);
        chk("to_kv", a_kv, 3'b111);
        chk("to_t1i", a_t1i, 11'd2);
`else
        idle(20);
        chk("to_busy", a_busy, 1);
        chk("to_err0", a_te, 0);
        chk("to_rv0", a_rv, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
